// File: rtl/tour_pkg.sv
// tour_pkg: shared types and constants for the knight's-tour command sequencer.
//   - tour_state_t : sequencer FSM states
//   - opcodes, headings and response bytes used to build commands
//   - DX_TBL / DY_TBL : signed square deltas for each one-hot move bit
//   - abs4() : magnitude of a small signed delta as a 4-bit squares field
package tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VERT      = 3'd1,
        ST_VERT_WAIT = 3'd2,
        ST_HORZ      = 3'd3,
        ST_HORZ_WAIT = 3'd4
    } tour_state_t;

    // Command opcodes (upper nibble of a 16-bit command)
    localparam logic [3:0] OP_MOVE    = 4'b0010;
    localparam logic [3:0] OP_MOVE_FF = 4'b0011;

    // Headings
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;
    localparam logic [7:0] HDG_W = 8'h3F;

    // Response bytes
    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] POS_ACK = 8'h5A;

    // Move bit i -> (dx, dy)
    localparam logic signed [3:0] DX_TBL [0:7] = '{
        4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1, 4'sd2, 4'sd2
    };
    localparam logic signed [3:0] DY_TBL [0:7] = '{
        4'sd2, 4'sd2, 4'sd1, -4'sd1, -4'sd2, -4'sd2, -4'sd1, 4'sd1
    };

    function automatic logic [3:0] abs4(input logic signed [3:0] v);
        logic [3:0] r;
        r = v[3] ? 4'(-v) : 4'(v);
        return r;
    endfunction

endpackage

// File: rtl/tour_move_decode.sv
// tour_move_decode: combinational translation of one solver move into the two
// robot commands that execute it.
//   move     in  8  : one-hot move (lowest set bit wins; zero means no motion)
//   vert_cmd out 16 : {MOVE, N/S heading, |dy|}
//   horz_cmd out 16 : {MOVE_FF, E/W heading, |dx|}
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic signed [3:0] dx;
    logic signed [3:0] dy;

    always_comb begin
        dx = '0;
        dy = '0;
        // Scan from the top down so the lowest set bit is the last to write.
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) begin
                dx = DX_TBL[i];
                dy = DY_TBL[i];
            end
        end
    end

    // dy == 0 and dx == 0 fall to south / west with zero squares.
    assign vert_cmd = {OP_MOVE,    (dy > 4'sd0) ? HDG_N : HDG_S, abs4(dy)};
    assign horz_cmd = {OP_MOVE_FF, (dx > 4'sd0) ? HDG_E : HDG_W, abs4(dx)};

endmodule

// File: rtl/tour_cmd.sv
// tour_cmd: walks the tour solver's move list and issues each move as a
// vertical then a horizontal command to the command processor. Outside a tour
// it passes UART commands straight through.
//   clk, rst_n    : clock, async active-low reset
//   start_tour    : pulse, solver move list is ready (honoured only in IDLE)
//   move / mv_indx: solver lookup (move is combinational from mv_indx)
//   cmd_UART, cmd_rdy_UART : UART command source (used in IDLE only)
//   cmd, cmd_rdy  : command to the command processor
//   clr_cmd_rdy   : processor accepted cmd
//   send_resp     : processor finished the accepted command
//   resp          : response byte to the UART wrapper
//   fsm_state     : current sequencer state, for observation
//
// Handshake: a command is offered while cmd_rdy=1 and held stable until the
// processor pulses clr_cmd_rdy; cmd_rdy drops the next cycle. The next command
// is only offered after send_resp, which is ignored until the clear has been
// seen. A clear arriving while waiting for send_resp is ignored.
module tour_cmd
    import tour_pkg::*;
#(
    parameter int unsigned NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp,
    output tour_state_t fsm_state
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    tour_state_t state, nxt_state;
    logic [4:0]  nxt_indx;
    logic [15:0] vert_cmd, horz_cmd;
    logic        last_move;

    tour_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx == LAST_INDX);
    assign fsm_state = state;

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mv_indx <= '0;
        end else begin
            state   <= nxt_state;
            mv_indx <= nxt_indx;
        end
    end

    // Next-state and next-index logic
    always_comb begin
        nxt_state = state;
        nxt_indx  = mv_indx;
        case (state)
            ST_IDLE: begin
                if (start_tour) begin
                    nxt_state = ST_VERT;
                    nxt_indx  = '0;
                end
            end
            ST_VERT: begin
                if (clr_cmd_rdy) nxt_state = ST_VERT_WAIT;
            end
            ST_VERT_WAIT: begin
                if (send_resp) nxt_state = ST_HORZ;
            end
            ST_HORZ: begin
                if (clr_cmd_rdy) nxt_state = ST_HORZ_WAIT;
            end
            ST_HORZ_WAIT: begin
                if (send_resp) begin
                    if (last_move) begin
                        nxt_state = ST_IDLE;
                    end else begin
                        nxt_state = ST_VERT;
                        nxt_indx  = mv_indx + 5'd1;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Output muxing
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = ACK;
        case (state)
            ST_IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = ACK;
            end
            ST_VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
                resp    = POS_ACK;
            end
            ST_VERT_WAIT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                resp    = POS_ACK;
            end
            ST_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                resp    = POS_ACK;
            end
            ST_HORZ_WAIT: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                // Final acknowledge once the last move's horizontal leg is done
                resp    = last_move ? ACK : POS_ACK;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = ACK;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// tb_tour_cmd: self-checking bench for tour_cmd. A behavioural solver table
// drives move from mv_indx; a reference model builds the expected command
// stream for each tour, and a randomized command-processor partner consumes it.
module tb_tour_cmd;
    import tour_pkg::*;

    localparam int NM = 24;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
    tour_state_t fsm_state;

    logic [7:0]  tour [0:31];
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Solver model: combinational lookup of the current move
    assign move = tour[mv_indx];

    tour_cmd #(.NUM_MOVES(NM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .resp         (resp),
        .fsm_state    (fsm_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Knight move -> (dx,dy) by lowest set bit, then build the two commands.
    function automatic void ref_cmds(input logic [7:0] m, output logic [15:0] v,
                                     output logic [15:0] h);
        int dxs [8];
        int dys [8];
        int dx, dy, sel;
        dxs = '{1, -1, -2, -2, -1, 1, 2, 2};
        dys = '{2, 2, 1, -1, -2, -2, -1, 1};
        dx = 0;
        dy = 0;
        sel = -1;
        for (int i = 0; i < 8; i++) if (m[i] && sel < 0) sel = i;
        if (sel >= 0) begin
            dx = dxs[sel];
            dy = dys[sel];
        end
        v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
        h = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    endfunction

    function automatic logic [7:0] rand_move();
        logic [7:0] m;
        case ($urandom_range(0, 9))
            0:       m = 8'($urandom);             // possibly multi-hot or zero
            1:       m = 8'h00;
            default: m = 8'(1 << $urandom_range(0, 7));
        endcase
        return m;
    endfunction

    task automatic load_tour();
        logic [15:0] v, h;
        exp_q.delete();
        for (int i = 0; i < NM; i++) begin
            ref_cmds(tour[i], v, h);
            exp_q.push_back(v);
            exp_q.push_back(h);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    // Partner model for command number k of a tour (k/2 = move, k%2 = horizontal).
    // Entered one time step after a clock edge with the command expected on offer.
    task automatic serve(input int k);
        logic [15:0] e;
        int          idx;
        logic        hz, last;
        idx  = k / 2;
        hz   = (k % 2) == 1;
        last = (k == 2 * NM - 1);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("cmd_rdy_offer", cmd_rdy, 1'b1);
        check("cmd", cmd, e);
        check("mv_indx", mv_indx, idx);
        check("resp_busy", resp, 8'h5A);
        // Early send_resp / noisy UART ready: must not release the command
        repeat ($urandom_range(0, 2)) begin
            send_resp    = 1'($urandom_range(0, 1));
            cmd_rdy_UART = 1'($urandom_range(0, 1));
            tick();
            send_resp = 1'b0;
            check("cmd_rdy_hold", cmd_rdy, 1'b1);
            check("cmd_hold", cmd, e);
        end
        // Accept, sometimes with a simultaneous send_resp which must be ignored
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'($urandom_range(0, 1));
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        cmd_rdy_UART = 1'b1;
        check("cmd_rdy_drop", cmd_rdy, 1'b0);
        check("resp_wait", resp, (last) ? 8'hA5 : 8'h5A);
        // Execution time with stray clears and start pulses
        repeat ($urandom_range(0, 2)) begin
            clr_cmd_rdy = 1'($urandom_range(0, 1));
            start_tour  = 1'($urandom_range(0, 1));
            tick();
            clr_cmd_rdy = 1'b0;
            start_tour  = 1'b0;
            check("cmd_rdy_wait", cmd_rdy, 1'b0);
            check("mv_indx_wait", mv_indx, idx);
        end
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        if (last) begin
            check("end_idle", fsm_state, ST_IDLE);
            check("end_resp", resp, 8'hA5);
            check("end_passthru", cmd, cmd_UART);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        cmd_UART     = 16'h2003;
        cmd_rdy_UART = 1'b1;
        for (int i = 0; i < 32; i++) tour[i] = 8'h00;
        repeat (3) tick();

        // Reset state and pass-through
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_indx", mv_indx, 5'd0);
        check("rst_cmd", cmd, 16'h2003);
        check("rst_cmd_rdy", cmd_rdy, 1'b1);
        check("rst_resp", resp, 8'hA5);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] c;
            logic        r;
            c = 16'($urandom);
            r = 1'($urandom_range(0, 1));
            cmd_UART     = c;
            cmd_rdy_UART = r;
            tick();
            check("pass_cmd", cmd, c);
            check("pass_rdy", cmd_rdy, r);
            check("pass_resp", resp, 8'hA5);
        end

        // Tour 1: directed first moves, then random, full length
        tour[0] = 8'h01;
        tour[1] = 8'h08;
        for (int i = 2; i < NM; i++) tour[i] = rand_move();
        load_tour();
        cmd_rdy_UART = 1'b0;
        pulse_start();
        check("start_rdy", cmd_rdy, 1'b1);
        check("dec_v01", cmd, 16'h2002);
        serve(0);
        check("dec_h01", cmd, 16'h3BF1);
        serve(1);
        check("dec_v08", cmd, 16'h27F1);
        serve(2);
        check("dec_h08", cmd, 16'h33F2);
        serve(3);
        for (int k = 4; k < 2 * NM; k++) serve(k);

        // Tour 2: reset in the middle of move 7
        for (int i = 0; i < NM; i++) tour[i] = rand_move();
        load_tour();
        tick();
        pulse_start();
        for (int k = 0; k < 14; k++) serve(k);
        check("pre_rst_indx", mv_indx, 5'd7);
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", fsm_state, ST_IDLE);
        check("abort_indx", mv_indx, 5'd0);
        check("abort_rdy", cmd_rdy, cmd_rdy_UART);
        check("abort_resp", resp, 8'hA5);
        tick();
        rst_n = 1'b1;
        tick();

        // Tour 3: restart from index 0, directed start_tour inside the tour
        for (int i = 0; i < NM; i++) tour[i] = rand_move();
        load_tour();
        pulse_start();
        for (int k = 0; k < 6; k++) serve(k);
        pulse_start();
        for (int k = 6; k < 2 * NM; k++) serve(k);
        check("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
